sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 1476146582, 32-bit system ID expected at word address 1.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 0, 32-bit timestamp expected at word address 0.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles allowed per read phase; legal range 1..65535.
REQ-004 Parameter AUTO_START, default 1, when 1 a check sequence begins automatically after reset.
REQ-005 Ports: one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to run a check sequence.
REQ-009 avm_address  output  1  Avalon-MM word address (1 = ID, 0 = timestamp).
REQ-010 avm_read  output  1  Avalon-MM read request.
REQ-011 avm_waitrequest  input  1  slave stall; request accepted in a cycle where avm_read=1 and avm_waitrequest=0.
REQ-012 avm_readdata  input  32  read data, valid when avm_readdatavalid=1.
REQ-013 avm_readdatavalid  input  1  read response strobe.
REQ-014 busy  output  1  sequence in progress.
REQ-015 done  output  1  sequence complete; level, held until next sequence starts.
REQ-016 id_match  output  1  captured ID equals EXPECTED_ID.
REQ-017 ts_match  output  1  captured timestamp equals EXPECTED_TIMESTAMP.
REQ-018 timeout_err  output  1  a phase exceeded TIMEOUT_CYCLES.
REQ-019 id_value  output  32  captured ID word.
REQ-020 ts_value  output  32  captured timestamp word.

Function
REQ-021 FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FIN.
REQ-022 IDLE -> REQ_ID on start=1 (or first cycle after reset when AUTO_START=1); entering REQ_ID clears done, id_match, ts_match, timeout_err, id_value, ts_value.
REQ-023 REQ_ID: avm_read=1, avm_address=1, held stable until acceptance; on acceptance -> WAIT_ID next cycle with avm_read=0.
REQ-024 WAIT_ID: on avm_readdatavalid=1 capture avm_readdata into id_value, set id_match by 32-bit equality, -> REQ_TS.
REQ-025 REQ_TS/WAIT_TS: identical to REQ_ID/WAIT_ID with avm_address=0, capture into ts_value, compare to EXPECTED_TIMESTAMP, then -> FIN.
REQ-026 FIN: done=1, busy=0, -> IDLE next cycle; done, flags and captured values hold in IDLE.
REQ-027 busy=1 in REQ_ID, WAIT_ID, REQ_TS, WAIT_TS; 0 otherwise.
REQ-028 At most one read outstanding; avm_read never asserted in WAIT_* states, FIN or IDLE.
REQ-029 avm_readdatavalid outside WAIT_* states, or in the acceptance cycle itself, is ignored.
REQ-030 16-bit phase counter clears on entry to each REQ_* state and increments every cycle in REQ_*/WAIT_*; reaching TIMEOUT_CYCLES without completing the phase sets timeout_err=1, drops avm_read, -> FIN; unreached match flags stay 0.
REQ-031 start while busy=1 is ignored; start in IDLE with done=1 begins a new sequence.
REQ-032 Zero-wait slave (waitrequest=0, readdatavalid one cycle after acceptance): start at cycle N -> done=1 at cycle N+5.

Reset
REQ-033 Reset=1 sampled at a rising edge forces IDLE; avm_read=0, avm_address=0, busy=0, done=0, id_match=0, ts_match=0, timeout_err=0, id_value=0, ts_value=0, counter=0.
REQ-034 Reset mid-sequence aborts immediately; avm_read=0 on the cycle after reset is sampled; late responses after reset are ignored.
REQ-035 With AUTO_START=1, REQ_ID is entered on the first cycle with reset=0 following reset.

Verification
REQ-036 Zero-wait slave returning 1476146582 at addr 1 and 0 at addr 0, AUTO_START=1 -> id_match=1, ts_match=1, timeout_err=0, done=1 five cycles after reset release.
REQ-037 waitrequest held 3 cycles on ID read -> avm_address=1 and avm_read=1 stable for all 4 cycles; exactly one accepted read per address.
REQ-038 Slave returns 0x12345678 at addr 1 -> id_value=0x12345678, id_match=0, ts_match=1, done=1.
REQ-039 TIMEOUT_CYCLES=10, readdatavalid never asserted -> timeout_err=1, done=1, avm_read=0, id_match=0, ts_match=0.
REQ-040 start pulsed during WAIT_ID and reset asserted during WAIT_TS -> start ignored; after reset all outputs zero, late readdatavalid ignored.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system-ID word (address 1) and the timestamp word
//   (address 0) over Avalon-MM and compares each against its expected value.
// Latency: with a zero-wait slave, start in cycle N gives done=1 in cycle N+5.
// Backpressure: avm_read and avm_address hold steady while avm_waitrequest=1.
//   Each read phase (request plus response wait) is bounded by TIMEOUT_CYCLES;
//   when a phase runs out of time the sequence ends with timeout_err=1.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   start                 one-cycle request to run a check (accepted in IDLE only)
//   avm_*                 Avalon-MM read master, one read outstanding at most
//   busy                  high while a read phase is in progress
//   done                  level, set at completion, held until the next sequence
//   id_match, ts_match    result of the 32-bit comparisons
//   timeout_err           a read phase ran out of cycles
//   id_value, ts_value    captured words
//
// TIMEOUT_CYCLES must lie in 1..65535 because the phase counter is 16 bits.

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd1476146582,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic        AUTO_INIT   = (AUTO_START != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  // Pending automatic start; armed by reset and consumed when leaving IDLE.
  logic        auto_q, auto_d;

  logic [15:0] cnt_inc;
  logic        phase_expire;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    id_match_d  = id_match_q;
    ts_match_d  = ts_match_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    auto_d      = auto_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;

    // The current cycle is the last one the phase may use when the count
    // would reach the limit after it.
    cnt_inc      = cnt_q + 16'd1;
    phase_expire = (cnt_inc == TIMEOUT_LIM);

    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d    = REQ_ID;
          cnt_d      = 16'd0;
          done_d     = 1'b0;
          id_match_d = 1'b0;
          ts_match_d = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
          auto_d     = 1'b0;
        end
      end

      REQ_ID: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = 1'b1;
        cnt_d       = cnt_inc;
        if (phase_expire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = FIN;
        end else if (!avm_waitrequest) begin
          state_d = WAIT_ID;
        end
      end

      WAIT_ID: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          id_match_d = (avm_readdata == EXPECTED_ID);
          cnt_d      = 16'd0;
          state_d    = REQ_TS;
        end else if (phase_expire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = FIN;
        end
      end

      REQ_TS: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        cnt_d    = cnt_inc;
        if (phase_expire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = FIN;
        end else if (!avm_waitrequest) begin
          state_d = WAIT_TS;
        end
      end

      WAIT_TS: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          ts_match_d = (avm_readdata == EXPECTED_TIMESTAMP);
          done_d     = 1'b1;
          state_d    = FIN;
        end else if (phase_expire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      done_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      auto_q     <= AUTO_INIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      auto_q     <= auto_d;
    end
  end

  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed bench for sysid_checker with a hand-driven slave.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
// Runs with TIMEOUT_CYCLES=10 so the timeout path completes quickly.

module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1476146582;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_id = 0;
  int acc_ts = 0;
  int a_id0;
  int a_ts0;

  sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (32'd0),
    .TIMEOUT_CYCLES     (10),
    .AUTO_START         (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  // Count read requests the slave accepts, per address.
  always @(posedge clock) begin
    if (avm_read && !avm_waitrequest) begin
      if (avm_address) acc_id++;
      else             acc_ts++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    tick(); tick();

    // Reset state
    chk("rst_read",  avm_read, 1'b0);
    chk("rst_addr",  avm_address, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_flags", {id_match, ts_match, timeout_err}, 3'b000);
    chk("rst_idv",   id_value, 32'd0);
    chk("rst_tsv",   ts_value, 32'd0);

    // Auto start, zero-wait slave, both words correct
    reset = 1'b0;
    tick();                                            // REQ_ID
    chk("t1_req_id", {avm_read, avm_address, busy}, 3'b111);
    tick();                                            // WAIT_ID
    chk("t1_wait_id", {avm_read, busy}, 2'b01);
    avm_readdatavalid = 1'b1; avm_readdata = EXP_ID;
    tick();                                            // REQ_TS
    avm_readdatavalid = 1'b0;
    chk("t1_req_ts", {avm_read, avm_address, busy}, 3'b101);
    chk("t1_idv", id_value, EXP_ID);
    chk("t1_idm", id_match, 1'b1);
    tick();                                            // WAIT_TS
    avm_readdatavalid = 1'b1; avm_readdata = 32'd0;
    tick();                                            // FIN, 5 cycles after release
    avm_readdatavalid = 1'b0;
    chk("t1_done", {done, busy, avm_read}, 3'b100);
    chk("t1_flags", {id_match, ts_match, timeout_err}, 3'b110);
    tick();                                            // IDLE
    chk("t1_hold", {done, id_match, ts_match, busy}, 4'b1110);
    chk("t1_acc_id", acc_id, 32'd1);
    chk("t1_acc_ts", acc_ts, 32'd1);

    // Stalled ID request, wrong ID, response in the acceptance cycle ignored
    a_id0 = acc_id; a_ts0 = acc_ts;
    start = 1'b1; avm_waitrequest = 1'b1;
    tick();                                            // REQ_ID
    start = 1'b0;
    chk("t2_clear", {done, id_match, ts_match}, 3'b000);
    chk("t2_clr_idv", id_value, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall", {avm_read, avm_address}, 2'b11);
      tick();
    end
    avm_waitrequest = 1'b0;
    chk("t2_stall_last", {avm_read, avm_address}, 2'b11);
    tick();                                            // WAIT_ID
    chk("t2_wait", {avm_read, busy}, 2'b01);
    tick();                                            // still WAIT_ID
    chk("t2_wait2", {avm_read, busy}, 2'b01);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h12345678;
    tick();                                            // REQ_TS
    avm_readdata = 32'hDEADBEEF;                       // acceptance cycle
    tick();                                            // WAIT_TS
    chk("t2_acc_cycle_ignored", ts_value, 32'd0);
    avm_readdata = 32'd0;
    tick();                                            // FIN
    avm_readdatavalid = 1'b0;
    chk("t2_idv", id_value, 32'h12345678);
    chk("t2_flags", {id_match, ts_match, timeout_err}, 3'b010);
    chk("t2_done", done, 1'b1);
    chk("t2_one_id_read", acc_id - a_id0, 32'd1);
    chk("t2_one_ts_read", acc_ts - a_ts0, 32'd1);
    tick();                                            // IDLE

    // Timeout: no response to the ID read
    start = 1'b1;
    tick();                                            // REQ_ID, count 0
    start = 1'b0;
    repeat (9) tick();                                 // WAIT_ID, count 9
    chk("t3_pre", {busy, timeout_err, done}, 3'b100);
    tick();                                            // FIN
    chk("t3_to", {timeout_err, done, avm_read, id_match, ts_match}, 5'b11000);
    chk("t3_busy", busy, 1'b0);
    tick();                                            // IDLE

    // Start while busy, then reset in WAIT_TS with a late response
    start = 1'b1;
    tick();                                            // REQ_ID
    start = 1'b0;
    tick();                                            // WAIT_ID
    start = 1'b1;
    tick();                                            // still WAIT_ID
    start = 1'b0;
    chk("t4_start_ignored", {busy, avm_read}, 2'b10);
    avm_readdatavalid = 1'b1; avm_readdata = EXP_ID;
    tick();                                            // REQ_TS
    avm_readdatavalid = 1'b0;
    chk("t4_idm", id_match, 1'b1);
    tick();                                            // WAIT_TS
    reset = 1'b1;
    tick();                                            // IDLE after reset
    chk("t4_rst_ctl", {avm_read, avm_address, busy, done, id_match, ts_match, timeout_err}, 7'd0);
    chk("t4_rst_idv", id_value, 32'd0);
    chk("t4_rst_tsv", ts_value, 32'd0);
    reset = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'd0;   // late response
    tick();                                            // REQ_ID via auto start
    chk("t4_auto", {avm_read, avm_address, busy}, 3'b111);
    chk("t4_late_ignored", {ts_match, done}, 2'b00);
    chk("t4_late_tsv", ts_value, 32'd0);
    avm_readdatavalid = 1'b0;
    tick();                                            // WAIT_ID
    avm_readdatavalid = 1'b1; avm_readdata = EXP_ID;
    tick();                                            // REQ_TS
    avm_readdatavalid = 1'b0;
    tick();                                            // WAIT_TS
    avm_readdatavalid = 1'b1; avm_readdata = 32'd0;
    tick();                                            // FIN
    avm_readdatavalid = 1'b0;
    chk("t4_final", {done, id_match, ts_match, timeout_err}, 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
